// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// holds the IF/ID register, applying redirects, flushes, stalls and run/halt control.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [6:0]  HALT_OP   = 7'b1111111,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Stall,
   input  logic        PCSrc,
   input  logic        clear,
   input  logic [31:0] Target,
   output logic [31:0] IAddr,
   input  logic [31:0] IData,
   output logic [31:0] ID_PC,
   output logic [31:0] ID_Instr,
   output logic        ID_Valid,
   output logic        Halted,
   output logic [31:0] FetchCount
);

   typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_id_pc;
   logic [31:0] r_id_instr;
   logic        r_id_valid;
   logic [31:0] r_fetch_cnt;
   logic [31:0] w_pc_inc;
   logic        w_is_halt;

   assign w_pc_inc  = r_pc + 32'd4;
   assign w_is_halt = (IData[6:0] == HALT_OP);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state     <= S_RUN;
         r_pc        <= RESET_PC;
         r_id_pc     <= '0;
         r_id_instr  <= NOP_INSTR;
         r_id_valid  <= 1'b0;
         r_fetch_cnt <= '0;
      end else if (PCSrc) begin
         // Redirect wins over stall and also cancels a halt.
         r_state    <= S_RUN;
         r_pc       <= {Target[31:2], 2'b00};
         r_id_pc    <= '0;
         r_id_instr <= NOP_INSTR;
         r_id_valid <= 1'b0;
      end else if (clear) begin
         r_id_pc    <= '0;
         r_id_instr <= NOP_INSTR;
         r_id_valid <= 1'b0;
         if (r_state == S_RUN && !Stall)
            r_pc <= w_pc_inc;
      end else if (Stall) begin
         r_pc <= r_pc;
      end else if (r_state == S_RUN) begin
         r_id_pc     <= r_pc;
         r_id_instr  <= IData;
         r_id_valid  <= 1'b1;
         r_fetch_cnt <= r_fetch_cnt + 32'd1;
         // The halt instruction itself is accepted, but the PC parks on it.
         if (w_is_halt)
            r_state <= S_HALT;
         else
            r_pc <= w_pc_inc;
      end else begin
         r_id_pc    <= '0;
         r_id_instr <= NOP_INSTR;
         r_id_valid <= 1'b0;
      end
   end

   assign IAddr      = r_pc;
   assign ID_PC      = r_id_pc;
   assign ID_Instr   = r_id_instr;
   assign ID_Valid   = r_id_valid;
   assign Halted     = (r_state == S_HALT);
   assign FetchCount = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table followed by random
// traffic checked against a rule-level reference model.
module tb_fetch_stage;

   logic        CLK = 1'b0;
   logic        RST, Stall, PCSrc, clear;
   logic [31:0] Target, IAddr, IData, ID_PC, ID_Instr, FetchCount;
   logic        ID_Valid, Halted;

   logic        use_rand = 1'b0;
   logic [31:0] r_data   = 32'h0;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   // Directed memory: addi x0,x0,imm with imm = addr[11:0], halt opcode at 0x30.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h30) return 32'h0000_007F;
      return {a[11:0], 20'h00013};
   endfunction

   assign IData = use_rand ? r_data : mem_word(IAddr);

   fetch_stage dut (
      .CLK(CLK), .RST(RST), .Stall(Stall), .PCSrc(PCSrc), .clear(clear),
      .Target(Target), .IAddr(IAddr), .IData(IData), .ID_PC(ID_PC),
      .ID_Instr(ID_Instr), .ID_Valid(ID_Valid), .Halted(Halted),
      .FetchCount(FetchCount)
   );

   // Reference model state
   logic [31:0] m_pc, m_idpc, m_instr, m_cnt;
   logic        m_v, m_h;

   task automatic model_step();
      bit adv;
      if (!RST) begin
         m_pc = 0; m_idpc = 0; m_instr = 32'h13; m_v = 0; m_h = 0; m_cnt = 0;
      end else if (PCSrc) begin
         m_pc = Target & ~32'd3; m_idpc = 0; m_instr = 32'h13; m_v = 0; m_h = 0;
      end else begin
         adv = !m_h && !Stall;
         if (clear) begin
            m_idpc = 0; m_instr = 32'h13; m_v = 0;
            if (adv) m_pc = m_pc + 4;
         end else if (Stall) begin
         end else if (!m_h) begin
            m_idpc = m_pc; m_instr = IData; m_v = 1; m_cnt = m_cnt + 1;
            if (IData[6:0] == 7'h7F) m_h = 1;
            else m_pc = m_pc + 4;
         end else begin
            m_idpc = 0; m_instr = 32'h13; m_v = 0;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic rs, input logic st, input logic ps,
                        input logic cl, input logic [31:0] tg);
      RST = rs; Stall = st; PCSrc = ps; clear = cl; Target = tg;
      #1;
      model_step();
      @(posedge CLK);
      #1;
   endtask

   typedef struct {
      logic        rst, stall, pcsrc, clr;
      logic [31:0] tgt;
      logic [31:0] iaddr, idpc;
      logic        v, h;
      logic [31:0] cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] exp_instr(input logic v, input logic [31:0] pc);
      if (!v) return 32'h0000_0013;
      if (pc == 32'h30) return 32'h0000_007F;
      return {pc[11:0], 20'h00013};
   endfunction

   initial begin
      RST = 0; Stall = 0; PCSrc = 0; clear = 0; Target = 0;
      //               rst st ps cl target         iaddr          idpc           v  h  cnt
      tbl.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h4,        32'h0,        1, 0, 1});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h8,        32'h4,        1, 0, 2});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'hC,        32'h8,        1, 0, 3});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h10,       32'hC,        1, 0, 4});
      tbl.push_back('{1, 0, 1, 0, 32'h102,      32'h100,      32'h0,        0, 0, 4});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h104,      32'h100,      1, 0, 5});
      tbl.push_back('{1, 0, 1, 0, 32'h20,       32'h20,       32'h0,        0, 0, 5});
      tbl.push_back('{1, 1, 0, 0, 32'h0,        32'h20,       32'h0,        0, 0, 5});
      tbl.push_back('{1, 1, 0, 0, 32'h0,        32'h20,       32'h0,        0, 0, 5});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h24,       32'h20,       1, 0, 6});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h28,       32'h24,       1, 0, 7});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h2C,       32'h28,       1, 0, 8});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h30,       32'h2C,       1, 0, 9});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h30,       32'h30,       1, 1, 10});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h30,       32'h0,        0, 1, 10});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h30,       32'h0,        0, 1, 10});
      tbl.push_back('{1, 1, 0, 0, 32'h0,        32'h30,       32'h0,        0, 1, 10});
      tbl.push_back('{1, 0, 1, 0, 32'h40,       32'h40,       32'h0,        0, 0, 10});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h44,       32'h40,       1, 0, 11});
      tbl.push_back('{1, 1, 0, 1, 32'h0,        32'h44,       32'h0,        0, 0, 11});
      tbl.push_back('{1, 1, 1, 0, 32'h80,       32'h80,       32'h0,        0, 0, 11});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h84,       32'h80,       1, 0, 12});
      tbl.push_back('{1, 0, 0, 1, 32'h0,        32'h88,       32'h0,        0, 0, 12});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h8C,       32'h88,       1, 0, 13});
      tbl.push_back('{1, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0,        0, 0, 13});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h0,        32'hFFFFFFFC, 1, 0, 14});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h4,        32'h0,        1, 0, 15});
      tbl.push_back('{0, 0, 1, 0, 32'h200,      32'h0,        32'h0,        0, 0, 0});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h4,        32'h0,        1, 0, 1});
      tbl.push_back('{1, 0, 1, 0, 32'h2C,       32'h2C,       32'h0,        0, 0, 1});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h30,       32'h2C,       1, 0, 2});
      // Halt opcode fetched under a flush must not halt.
      tbl.push_back('{1, 0, 0, 1, 32'h0,        32'h34,       32'h0,        0, 0, 2});
      tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h38,       32'h34,       1, 0, 3});

      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].rst, tbl[i].stall, tbl[i].pcsrc, tbl[i].clr, tbl[i].tgt);
         chk($sformatf("vec%0d.IAddr", i),      IAddr,             tbl[i].iaddr);
         chk($sformatf("vec%0d.ID_PC", i),      ID_PC,             tbl[i].idpc);
         chk($sformatf("vec%0d.ID_Instr", i),   ID_Instr,          exp_instr(tbl[i].v, tbl[i].idpc));
         chk($sformatf("vec%0d.ID_Valid", i),   {31'h0, ID_Valid}, {31'h0, tbl[i].v});
         chk($sformatf("vec%0d.Halted", i),     {31'h0, Halted},   {31'h0, tbl[i].h});
         chk($sformatf("vec%0d.FetchCount", i), FetchCount,        tbl[i].cnt);
      end

      // Random traffic against the reference model.
      use_rand = 1'b1;
      r_data   = $urandom;
      cycle(0, 0, 0, 0, 32'h0);
      for (int i = 0; i < 2000; i++) begin
         r_data = $urandom;
         if ($urandom_range(0, 7) == 0) r_data[6:0] = 7'h7F;
         cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), $urandom);
         chk($sformatf("rnd%0d.IAddr", i),      IAddr,             m_pc);
         chk($sformatf("rnd%0d.ID_PC", i),      ID_PC,             m_idpc);
         chk($sformatf("rnd%0d.ID_Instr", i),   ID_Instr,          m_instr);
         chk($sformatf("rnd%0d.ID_Valid", i),   {31'h0, ID_Valid}, {31'h0, m_v});
         chk($sformatf("rnd%0d.Halted", i),     {31'h0, Halted},   {31'h0, m_h});
         chk($sformatf("rnd%0d.FetchCount", i), FetchCount,        m_cnt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
